sha256_block_sequencer: RTL and testbench
=========================================

Name: sha256_block_sequencer

Overview:
- Sequences a byte-addressed message in word memory into padded 512-bit SHA-256 blocks.
- Streams each block as 16 big-endian 32-bit words to the compression core, one block per core handshake.
- Inserts the 0x80 pad byte, the zero fill and the 64-bit bit-length field.
- Sits between the message memory and the SHA-256 compression core. Computes its own block count with the team's standard rule.

Parameters:
ADDR_W, 16, word-address width of message memory
SIZE_W, 32, width of message byte-size input

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse: begin a message; ignored unless in IDLE
message_addr  in  ADDR_W  word address of message byte 0
size  in  SIZE_W  message length in bytes
mem_re  out  1  memory read enable
mem_addr  out  ADDR_W  memory word address
mem_read_data  in  32  read data, valid exactly 1 cycle after mem_re; byte 0 in [31:24]
core_ready  in  1  core can accept a new 16-word block
blk_word  out  32  padded block word
blk_word_valid  out  1  blk_word is valid this cycle
blk_word_idx  out  4  index 0..15 of blk_word within the block
blk_first  out  1  current block is block 0 (held with blk_word_valid)
blk_last  out  1  current block is the final block (held with blk_word_valid)
busy  out  1  high from the cycle after accepted start until done
done  out  1  single-cycle pulse after the last word of the last block

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs go to 0, including mem_addr and blk_word.
  - Internal counters are cleared.
  - Any in-flight read result is discarded.
- Block count: latched at start.
  - nb = (size>>6) + (size[5:0] < 56 ? 1 : 2), truncated to 16 bits.
  - len64 = {29'b0, size} << 3, i.e. bit length, 64 bits.
  - size, message_addr and len64 are latched on start.
- IDLE: on start, go to WAIT_CORE with blk_cnt=0.
- WAIT_CORE: on core_ready=1, go to FETCH with word_cnt=0. Otherwise hold indefinitely.
- FETCH: one word issued per cycle, word_cnt 0..15. Global word g = blk_cnt*16 + word_cnt.
  - If 4g < size: mem_re=1 and mem_addr = message_addr + g (wraps modulo 2^ADDR_W).
  - Otherwise mem_re=0. No memory access is made for padding-only words.
  - Exactly 16 cycles, no stalls. After word_cnt 15, go to DRAIN.
- Output stage: registered, 1 cycle after issue. blk_word_valid is high 16 consecutive cycles per block.
  - blk_word_idx = issued word_cnt.
  - Byte j (0..3, MSB first) at position p = 4g+j:
    - p < size: the memory byte.
    - p == size: 0x80.
    - p > size: 0x00.
  - Override in the last block: idx 14 = len64[63:32], idx 15 = len64[31:0].
  - The override never collides with message or 0x80 bytes, by the block-count rule.
- DRAIN (1 cycle, last word presented):
  - blk_cnt+1 < nb: increment blk_cnt, go to WAIT_CORE.
  - Otherwise: pulse done, go to IDLE.
- core_ready is sampled only in WAIT_CORE. Its deassertion during FETCH has no effect.
- start during busy is ignored. start in the same cycle done pulses is ignored; it is accepted from the next cycle.
- size=0 is legal: 1 block, no memory reads.

Decomposition:
- Shared package:
  - BLOCK_WORDS=16, PAD_BYTE=8'h80, LEN_LIMIT=56.
  - Sequencer state enum {IDLE, WAIT_CORE, FETCH, DRAIN}.
  - determine_num_blocks function, shared with the existing block-count logic so both use the same rule.
- One sub-module: sha256_pad_word. Combinational.
  - Inputs: raw word, g, size, len64, last flag, idx.
  - Output: padded word.
  - Instantiated once in the output stage.

Test Plan:
- size=0, core_ready=1 -> 1 block; no mem_re; word0=0x80000000; words1..15=0; done 1 cycle after word15.
- size=3, memory word0=0x61626364 ("abcd") -> word0=0x61626380, word14=0, word15=0x00000018, blk_first=blk_last=1.
- size=55 -> 1 block, word13=0x......80 (byte 55 = 0x80), word15=0x000001B8; size=56 -> 2 blocks, block 1 words 0..13=0, word15=0x000001C0.
- size=64 -> 2 blocks, 16 mem reads total; block 1 word0=0x80000000, word15=0x00000200, blk_last only on block 1.
- core_ready held 0 for 20 cycles between blocks -> stays in WAIT_CORE, blk_word_valid=0, no mem_re; resumes on the first cycle core_ready=1.
- reset asserted at word 7 of block 0 of a 130-byte message -> all outputs 0 immediately; a new start after release produces a correct full 3-block sequence.

Source files
------------

// File: rtl/sha256_block_sequencer_pkg.sv
// Shared constants, sequencer state encoding and the block-count rule
// for the SHA-256 block sequencer.
package sha256_block_sequencer_pkg;

  localparam int unsigned BLOCK_WORDS = 16;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;
  localparam logic [5:0]  LEN_LIMIT   = 6'd56;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CORE,
    FETCH,
    DRAIN
  } seq_state_e;

  // A tail of 56+ bytes leaves no room for the 0x80 byte plus the 8-byte length.
  function automatic logic [15:0] determine_num_blocks(input logic [31:0] size_bytes);
    logic [31:0] nb;
    nb = (size_bytes >> 6) + ((size_bytes[5:0] < LEN_LIMIT) ? 32'd1 : 32'd2);
    return nb[15:0];
  endfunction

endpackage

// File: rtl/sha256_block_sequencer_pad_word.sv
// Builds one padded block word from the raw memory word: message bytes,
// the 0x80 marker, zero fill, and the bit-length in the last two words.
module sha256_pad_word
  import sha256_block_sequencer_pkg::*;
#(
  parameter int unsigned SIZE_W = 32
) (
  input  logic [31:0]       raw_i,
  input  logic [19:0]       g_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic [63:0]       len64_i,
  input  logic              last_i,
  input  logic [3:0]        idx_i,
  output logic [31:0]       word_o
);

  logic [63:0] pos;
  logic [63:0] sz;

  always_comb begin
    word_o = '0;
    pos    = '0;
    sz     = 64'(size_i);
    for (int unsigned j = 0; j < 4; j++) begin
      pos = 64'({g_i, 2'b00}) + 64'(j);
      if (pos < sz)
        word_o[31-8*j -: 8] = raw_i[31-8*j -: 8];
      else if (pos == sz)
        word_o[31-8*j -: 8] = PAD_BYTE;
      else
        word_o[31-8*j -: 8] = '0;
    end
    if (last_i && idx_i == 4'd14)
      word_o = len64_i[63:32];
    else if (last_i && idx_i == 4'd15)
      word_o = len64_i[31:0];
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Streams a byte-addressed message from word memory as padded 512-bit
// SHA-256 blocks, 16 big-endian words per core handshake.
module sha256_block_sequencer
  import sha256_block_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned SIZE_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [SIZE_W-1:0] size,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  input  logic              core_ready,
  output logic [31:0]       blk_word,
  output logic              blk_word_valid,
  output logic [3:0]        blk_word_idx,
  output logic              blk_first,
  output logic              blk_last,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q;
  logic [15:0]       blk_cnt_q, nb_q;
  logic [3:0]        word_cnt_q;
  logic [SIZE_W-1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       len64_q;
  logic              mem_re_q, vld_q, first_q, last_q, busy_q, done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        idx_q;
  logic [19:0]       g_q;

  logic [3:0]        issue_word_d;
  logic [19:0]       issue_g_d;
  logic              issue_re_d;
  logic [ADDR_W-1:0] issue_addr_d;
  logic              blk_last_d;
  logic              more_blocks_d;
  logic [31:0]       pad_word;

  // Memory strobes are registered, so they are computed for the word issued next cycle.
  always_comb begin
    issue_word_d  = (state_q == WAIT_CORE) ? '0 : word_cnt_q + 4'd1;
    issue_g_d     = {blk_cnt_q, issue_word_d};
    issue_re_d    = 64'({issue_g_d, 2'b00}) < 64'(size_q);
    issue_addr_d  = addr_q + ADDR_W'(issue_g_d);
    blk_last_d    = (17'(blk_cnt_q) + 17'd1) == 17'(nb_q);
    more_blocks_d = (17'(blk_cnt_q) + 17'd1) < 17'(nb_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      blk_cnt_q  <= '0;
      nb_q       <= '0;
      word_cnt_q <= '0;
      size_q     <= '0;
      addr_q     <= '0;
      len64_q    <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      g_q        <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      case (state_q)
        IDLE: begin
          // done_q high means this is the done cycle; start is not yet accepted.
          if (start && !done_q) begin
            size_q    <= size;
            addr_q    <= message_addr;
            len64_q   <= 64'(size) << 3;
            nb_q      <= determine_num_blocks(32'(size));
            blk_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= WAIT_CORE;
          end
        end
        WAIT_CORE: begin
          if (core_ready) begin
            word_cnt_q <= '0;
            mem_re_q   <= issue_re_d;
            mem_addr_q <= issue_re_d ? issue_addr_d : '0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          vld_q   <= 1'b1;
          idx_q   <= word_cnt_q;
          g_q     <= {blk_cnt_q, word_cnt_q};
          first_q <= (blk_cnt_q == '0);
          last_q  <= blk_last_d;
          if (word_cnt_q == 4'(BLOCK_WORDS - 1)) begin
            state_q <= DRAIN;
          end else begin
            word_cnt_q <= issue_word_d;
            mem_re_q   <= issue_re_d;
            mem_addr_q <= issue_re_d ? issue_addr_d : '0;
          end
        end
        DRAIN: begin
          if (more_blocks_d) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
            state_q   <= WAIT_CORE;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sha256_pad_word #(
    .SIZE_W(SIZE_W)
  ) u_pad (
    .raw_i  (mem_read_data),
    .g_i    (g_q),
    .size_i (size_q),
    .len64_i(len64_q),
    .last_i (last_q),
    .idx_i  (idx_q),
    .word_o (pad_word)
  );

  // Read data arrives with the registered word metadata, so only the control is flopped.
  assign blk_word       = vld_q ? pad_word : '0;
  assign blk_word_valid = vld_q;
  assign blk_word_idx   = vld_q ? idx_q : '0;
  assign blk_first      = vld_q & first_q;
  assign blk_last       = vld_q & last_q;
  assign mem_re         = mem_re_q;
  assign mem_addr       = mem_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer: expected words and reads are
// queued at start and compared as the sequencer emits them.
module tb_sha256_block_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] message_addr;
  logic [31:0] size;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        core_ready;
  logic [31:0] blk_word;
  logic        blk_word_valid;
  logic [3:0]  blk_word_idx;
  logic        blk_first;
  logic        blk_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sha256_block_sequencer #(
    .ADDR_W(16),
    .SIZE_W(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .message_addr  (message_addr),
    .size          (size),
    .mem_re        (mem_re),
    .mem_addr      (mem_addr),
    .mem_read_data (mem_read_data),
    .core_ready    (core_ready),
    .blk_word      (blk_word),
    .blk_word_valid(blk_word_valid),
    .blk_word_idx  (blk_word_idx),
    .blk_first     (blk_first),
    .blk_last      (blk_last),
    .busy          (busy),
    .done          (done)
  );

  logic [31:0] mem [0:65535];

  // Garbage on idle cycles so padding words cannot silently reuse stale data.
  always @(posedge clk) begin
    if (mem_re) mem_read_data <= mem[mem_addr];
    else        mem_read_data <= $urandom;
  end

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic        done_due    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input logic [15:0] a, input int unsigned p);
    logic [31:0] w;
    logic [15:0] wa;
    wa = a + 16'(p / 4);
    w  = mem[wa];
    return w[31-8*(p%4) -: 8];
  endfunction

  // Independent padding model: message, 0x80, zeros, then 64-bit big-endian bit count.
  task automatic push_msg(input logic [15:0] a, input int unsigned sz);
    int unsigned nb;
    int unsigned p;
    logic [63:0] bits;
    logic [31:0] word;
    logic [7:0]  b;
    exp_t        e;
    nb   = (sz + 9 + 63) / 64;
    bits = 64'(sz) * 64'd8;
    for (int unsigned blk = 0; blk < nb; blk++) begin
      for (int unsigned w = 0; w < 16; w++) begin
        word = '0;
        for (int unsigned j = 0; j < 4; j++) begin
          p = blk * 64 + w * 4 + j;
          if (p < sz)       b = msg_byte(a, p);
          else if (p == sz) b = 8'h80;
          else              b = 8'h00;
          if (blk == nb - 1 && p >= nb * 64 - 8) b = bits[8*(nb*64-1-p) +: 8];
          word = {word[23:0], b};
        end
        e.w = word; e.idx = 4'(w); e.first = (blk == 0); e.last = (blk == nb - 1);
        exp_q.push_back(e);
      end
    end
    for (int unsigned g = 0; 4 * g < sz; g++) rd_q.push_back(a + 16'(g));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      exp_q.delete();
      rd_q.delete();
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        chk("done_pulse", 64'(done), 64'd1);
        done_due = 1'b0;
      end else if (done === 1'b1) begin
        chk("done_unexpected", 64'(done), 64'd0);
      end
      if (blk_word_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("word_unexpected", 64'(blk_word_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("blk_word",  64'(blk_word),     64'(e.w));
          chk("blk_idx",   64'(blk_word_idx), 64'(e.idx));
          chk("blk_first", 64'(blk_first),    64'(e.first));
          chk("blk_last",  64'(blk_last),     64'(e.last));
          if (e.last && e.idx == 4'd15) done_due = 1'b1;
        end
      end
      if (mem_re === 1'b1) begin
        if (rd_q.size() == 0) chk("read_unexpected", 64'(mem_re), 64'd0);
        else                  chk("mem_addr", 64'(mem_addr), 64'(rd_q.pop_front()));
      end
    end
  end

  task automatic start_msg(input logic [15:0] a, input int unsigned sz);
    @(negedge clk);
    message_addr = a;
    size         = sz;
    start        = 1'b1;
    push_msg(a, sz);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_reads_left"}, 64'(rd_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_re"},   64'(mem_re),         64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr),       64'd0);
    chk({tag, "_word"},     64'(blk_word),       64'd0);
    chk({tag, "_valid"},    64'(blk_word_valid), 64'd0);
    chk({tag, "_idx"},      64'(blk_word_idx),   64'd0);
    chk({tag, "_first"},    64'(blk_first),      64'd0);
    chk({tag, "_last"},     64'(blk_last),       64'd0);
    chk({tag, "_busy"},     64'(busy),           64'd0);
    chk({tag, "_done"},     64'(done),           64'd0);
  endtask

  initial begin
    int cyc;
    reset        = 1'b1;
    start        = 1'b0;
    message_addr = '0;
    size         = '0;
    core_ready   = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16'h0200] = 32'h6162_6364;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset      = 1'b0;
    core_ready = 1'b1;

    start_msg(16'h0100, 0);
    wait_done("size0");
    start_msg(16'h0200, 3);
    wait_done("size3");
    start_msg(16'h0300, 55);
    wait_done("size55");
    start_msg(16'h0400, 56);
    wait_done("size56");

    // Two blocks with address wrap; start on the done cycle must be dropped.
    start_msg(16'hFFF8, 64);
    wait_done("size64");
    message_addr = 16'h0500;
    size         = 5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_ignored", 64'(busy), 64'd0);

    // Core stalls between blocks; a start during busy must be ignored.
    start_msg(16'h1000, 100);
    cyc = 0;
    while (blk_word_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("gap_first_word", 64'(blk_word_valid), 64'd1);
    core_ready = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("gap_valid",  64'(blk_word_valid), 64'd0);
      chk("gap_mem_re", 64'(mem_re),         64'd0);
      chk("gap_busy",   64'(busy),           64'd1);
      if (i == 5) begin
        message_addr = 16'h7000;
        size         = 7;
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    core_ready = 1'b1;
    @(negedge clk);
    chk("resume_mem_re", 64'(mem_re), 64'd1);
    @(negedge clk);
    chk("resume_valid", 64'(blk_word_valid), 64'd1);
    wait_done("gap");

    // Reset in the middle of block 0, then a clean rerun.
    start_msg(16'h2000, 130);
    cyc = 0;
    while (!(blk_word_valid === 1'b1 && blk_word_idx === 4'd7) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reset_at_word7", 64'(blk_word_idx), 64'd7);
    #2 reset = 1'b1;
    #1 chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_msg(16'h2000, 130);
    wait_done("size130");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
